// File: rtl/rvfpm_xif_issue_queue_pkg.sv
// ============================================================================
// pa_rvfpm : shared types and opcode constants for the rvfpm XIF front-end
// Revision : 1.0
// ============================================================================
`default_nettype none

package pa_rvfpm;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_NUM_RS    = 3;
  localparam int X_RFR_WIDTH = 32;

  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

  typedef struct packed {
    logic [31:0]                             instr;
    logic [1:0]                              mode;
    logic [X_ID_WIDTH-1:0]                   id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]    rs;
    logic [X_NUM_RS-1:0]                     rs_valid;
    logic [5:0]                              ecs;
    logic                                    ecs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [31:0]                             instr;
    logic [X_ID_WIDTH-1:0]                   id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]    rs;
    logic                                    valid;
    logic                                    committed;
    logic                                    killed;
  } fpq_entry_t;

endpackage

`default_nettype wire

// File: rtl/rvfpm_xif_issue_queue_decode.sv
// ============================================================================
// rvfpm_xif_decode : combinational XIF issue decode for the rvfpm FPU
// Revision : 1.0
// ============================================================================
`default_nettype none

module rvfpm_xif_decode
  import pa_rvfpm::*;
(
  input  logic [31:0]   instr_i,
  output x_issue_resp_t issue_resp_o,
  output logic          needs_rs_o
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_funct5;
  logic [19:0] unused_instr_bits;

  assign w_opcode          = instr_i[6:0];
  assign w_funct5          = instr_i[31:27];
  assign unused_instr_bits = instr_i[26:7];

  always_comb begin
    issue_resp_o = '0;
    needs_rs_o   = 1'b0;
    case (w_opcode)
      OPC_OP_FP: begin
        issue_resp_o.accept    = 1'b1;
        // FCVT.W/FMV.X/compare class write the integer register file
        issue_resp_o.writeback = (w_funct5 == 5'b11000) || (w_funct5 == 5'b11100) ||
                                 (w_funct5 == 5'b10100);
        needs_rs_o             = (w_funct5 == 5'b11010) || (w_funct5 == 5'b11110);
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        issue_resp_o.accept = 1'b1;
      end
      OPC_LOAD_FP, OPC_STORE_FP: begin
        issue_resp_o.accept    = 1'b1;
        issue_resp_o.loadstore = 1'b1;
        needs_rs_o             = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rvfpm_xif_issue_queue.sv
// ============================================================================
// rvfpm_xif_issue_queue : XIF issue front-end with in-order commit-gated queue
// Revision : 1.0
// ============================================================================
`default_nettype none

module rvfpm_xif_issue_queue
  import pa_rvfpm::*;
#(
  parameter int X_ID_WIDTH  = pa_rvfpm::X_ID_WIDTH,
  parameter int X_NUM_RS    = pa_rvfpm::X_NUM_RS,
  parameter int X_RFR_WIDTH = pa_rvfpm::X_RFR_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  x_issue_req_t                    issue_req_i,
  output x_issue_resp_t                   issue_resp_o,
  input  logic                            commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]           commit_id_i,
  input  logic                            commit_kill_i,
  input  logic                            flush_i,
  output logic                            disp_valid_o,
  input  logic                            disp_ready_i,
  output logic [31:0]                     disp_instr_o,
  output logic [X_ID_WIDTH-1:0]           disp_id_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] disp_rs_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int PW = $clog2(DEPTH);

  fpq_entry_t      q_q [DEPTH];
  fpq_entry_t      q_d [DEPTH];
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   w_wr_idx, w_rd_idx;
  logic            w_needs_rs, w_full, w_push, w_pop, w_drop;
  x_commit_t       w_commit;
  fpq_entry_t      w_head, w_new;
  logic            unused_issue_bits;

  assign unused_issue_bits = ^{issue_req_i.mode, issue_req_i.ecs, issue_req_i.ecs_valid,
                               issue_req_i.rs_valid};

  rvfpm_xif_decode u_decode (
    .instr_i      (issue_req_i.instr),
    .issue_resp_o (issue_resp_o),
    .needs_rs_o   (w_needs_rs)
  );

  assign w_commit.id          = commit_id_i;
  assign w_commit.commit_kill = commit_kill_i;

  assign w_wr_idx = wr_ptr_q[PW-1:0];
  assign w_rd_idx = rd_ptr_q[PW-1:0];
  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign w_full   = (count_o == (PW+1)'(DEPTH));

  assign issue_ready_o = rst_ni & ~w_full & (~w_needs_rs | issue_req_i.rs_valid[0]);
  assign w_push        = issue_valid_i & issue_ready_o & issue_resp_o.accept;

  assign w_head       = q_q[w_rd_idx];
  assign disp_valid_o = rst_ni & w_head.valid & w_head.committed & ~w_head.killed;
  assign w_drop       = w_head.valid & w_head.killed;
  assign w_pop        = (disp_valid_o & disp_ready_i) | w_drop;

  assign disp_instr_o = disp_valid_o ? w_head.instr : '0;
  assign disp_id_o    = disp_valid_o ? w_head.id    : '0;
  assign disp_rs_o    = disp_valid_o ? w_head.rs    : '0;

  always_comb begin
    w_new.instr     = issue_req_i.instr;
    w_new.id        = issue_req_i.id;
    w_new.rs        = issue_req_i.rs;
    w_new.valid     = 1'b1;
    w_new.committed = 1'b0;
    w_new.killed    = 1'b0;
    // a commit for the id being issued lands directly in the new entry
    if (commit_valid_i && (w_commit.id == issue_req_i.id)) begin
      w_new.committed = ~w_commit.commit_kill;
      w_new.killed    = w_commit.commit_kill;
    end

    for (int i = 0; i < DEPTH; i++) begin
      q_d[i] = q_q[i];
      if (commit_valid_i && q_q[i].valid && !q_q[i].committed && !q_q[i].killed &&
          (q_q[i].id == w_commit.id)) begin
        q_d[i].committed = ~w_commit.commit_kill;
        q_d[i].killed    = w_commit.commit_kill;
      end
      if (w_pop && (PW'(i) == w_rd_idx)) begin
        q_d[i].valid = 1'b0;
      end
      if (w_push && (PW'(i) == w_wr_idx)) begin
        q_d[i] = w_new;
      end
    end

    wr_ptr_d = wr_ptr_q + (PW+1)'(w_push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(w_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rvfpm_xif_issue_queue.sv
// ============================================================================
// tb_rvfpm_xif_issue_queue : self-checking bench for rvfpm_xif_issue_queue
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rvfpm_xif_issue_queue;
  import pa_rvfpm::*;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic          issue_ready;
  x_issue_req_t  issue_req;
  x_issue_resp_t issue_resp;
  logic          commit_valid;
  logic [3:0]    commit_id;
  logic          commit_kill;
  logic          flush;
  logic          disp_valid;
  logic          disp_ready;
  logic [31:0]   disp_instr;
  logic [3:0]    disp_id;
  logic [95:0]   disp_rs;
  logic [2:0]    count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] instr;
    logic        acc;
    logic        wb;
    logic        ls;
    logic        nrs;
  } dec_vec_t;
  dec_vec_t vecs [15];

  always #5 clk = ~clk;

  rvfpm_xif_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_req_i    (issue_req),
    .issue_resp_o   (issue_resp),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .flush_i        (flush),
    .disp_valid_o   (disp_valid),
    .disp_ready_i   (disp_ready),
    .disp_instr_o   (disp_instr),
    .disp_id_o      (disp_id),
    .disp_rs_o      (disp_rs),
    .count_o        (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_req    = '0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] instr);
    issue_valid           = 1'b1;
    issue_req             = '0;
    issue_req.id          = id;
    issue_req.instr       = instr;
    issue_req.rs[0]       = {28'h0ABCDEF, id};
    issue_req.rs_valid    = 3'b111;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  // every dispatch handshake is matched against the scoreboard in order
  always @(negedge clk) begin
    if (disp_valid && disp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_dispatch: got id %0d expected none at %0t", disp_id, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("disp_id", 32'(disp_id), 32'(e.id));
        check("disp_instr", disp_instr, e.instr);
      end
    end
  end

  initial begin
    vecs[0]  = '{32'h0020F0D3, 1, 0, 0, 0};
    vecs[1]  = '{32'hE0000553, 1, 1, 0, 0};
    vecs[2]  = '{32'hC0000553, 1, 1, 0, 0};
    vecs[3]  = '{32'hA0002553, 1, 1, 0, 0};
    vecs[4]  = '{32'hF0000053, 1, 0, 0, 1};
    vecs[5]  = '{32'hD0000053, 1, 0, 0, 1};
    vecs[6]  = '{32'h00000043, 1, 0, 0, 0};
    vecs[7]  = '{32'h00000047, 1, 0, 0, 0};
    vecs[8]  = '{32'h0000004B, 1, 0, 0, 0};
    vecs[9]  = '{32'h0000004F, 1, 0, 0, 0};
    vecs[10] = '{32'h0000A007, 1, 0, 1, 1};
    vecs[11] = '{32'h0000A027, 1, 0, 1, 1};
    vecs[12] = '{32'h00B50533, 0, 0, 0, 0};
    vecs[13] = '{32'h00002003, 0, 0, 0, 0};
    vecs[14] = '{32'h58000053, 1, 0, 0, 0};

    idle();
    disp_ready = 1'b0;
    rst_n      = 1'b0;
    settle();
    check("rst_issue_ready", 32'(issue_ready), 0);
    check("rst_disp_valid", 32'(disp_valid), 0);
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_disp_id", 32'(disp_id), 0);
    rst_n = 1'b1;
    settle();

    // decode table, rs_valid=0 and issue_valid=0 so nothing is stored
    for (int i = 0; i < 15; i++) begin
      issue_req       = '0;
      issue_req.instr = vecs[i].instr;
      settle();
      check("dec_accept", 32'(issue_resp.accept), 32'(vecs[i].acc));
      check("dec_writeback", 32'(issue_resp.writeback), 32'(vecs[i].wb));
      check("dec_loadstore", 32'(issue_resp.loadstore), 32'(vecs[i].ls));
      check("dec_zero_flags", 32'({issue_resp.dualwrite, issue_resp.dualread,
                                   issue_resp.ecswrite, issue_resp.exc}), 0);
      check("dec_ready", 32'(issue_ready), 32'(!vecs[i].nrs));
    end
    tick();
    check("dec_count", 32'(count), 0);

    // FADD.S issued and committed together
    disp_ready = 1'b1;
    issue(4'd3, 32'h0020F0D3);
    commit(4'd3, 1'b0);
    settle();
    check("fadd_accept", 32'(issue_resp.accept), 1);
    check("fadd_wb", 32'(issue_resp.writeback), 0);
    check("fadd_ls", 32'(issue_resp.loadstore), 0);
    sb.push_back('{4'd3, 32'h0020F0D3});
    tick();
    idle();
    settle();
    check("fadd_disp_valid", 32'(disp_valid), 1);
    check("fadd_disp_id", 32'(disp_id), 3);
    check("fadd_disp_instr", disp_instr, 32'h0020F0D3);
    check("fadd_disp_rs0", disp_rs[31:0], 32'hABCDEF3);
    tick();
    check("fadd_count_after", 32'(count), 0);

    // non-FP ADD is acknowledged but not stored
    issue(4'd5, 32'h00B50533);
    settle();
    check("add_accept", 32'(issue_resp.accept), 0);
    check("add_ready", 32'(issue_ready), 1);
    tick();
    idle();
    settle();
    check("add_count", 32'(count), 0);
    check("add_disp_valid", 32'(disp_valid), 0);
    check("idle_disp_instr_zero", disp_instr, 0);

    // fill to DEPTH, then release one slot via commit and pop
    disp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 32'h00000053 | (32'(i) << 7));
      tick();
    end
    issue(4'd4, 32'h00000253);
    settle();
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(issue_ready), 0);
    disp_ready = 1'b1;
    commit(4'd0, 1'b0);
    sb.push_back('{4'd0, 32'h00000053});
    tick();
    commit_valid = 1'b0;
    settle();
    check("full_pop_ready_same_cycle", 32'(issue_ready), 0);
    check("full_pop_disp_valid", 32'(disp_valid), 1);
    tick();
    settle();
    check("full_ready_next_cycle", 32'(issue_ready), 1);
    check("full_count_after_pop", 32'(count), 3);
    tick();
    idle();
    settle();
    check("full_id4_taken", 32'(count), 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check("full_flush_count", 32'(count), 0);

    // kill id 1 then commit id 2
    issue(4'd1, 32'h00100053);
    tick();
    issue(4'd2, 32'h00200053);
    tick();
    idle();
    commit(4'd1, 1'b1);
    tick();
    commit(4'd2, 1'b0);
    sb.push_back('{4'd2, 32'h00200053});
    settle();
    check("kill_no_disp", 32'(disp_valid), 0);
    tick();
    idle();
    settle();
    for (int k = 0; k < 2 && !disp_valid; k++) tick();
    check("kill_next_disp_valid", 32'(disp_valid), 1);
    check("kill_next_disp_id", 32'(disp_id), 2);
    tick();
    check("kill_count_after", 32'(count), 0);

    // FLW waits for rs_valid[0]
    issue(4'd7, 32'h0000A007);
    issue_req.rs_valid = 3'b000;
    settle();
    check("flw_ready_low", 32'(issue_ready), 0);
    check("flw_loadstore", 32'(issue_resp.loadstore), 1);
    tick();
    check("flw_not_stored", 32'(count), 0);
    issue_req.rs_valid = 3'b001;
    settle();
    check("flw_ready_high", 32'(issue_ready), 1);
    tick();
    idle();
    settle();
    check("flw_stored", 32'(count), 1);

    // 3 entries queued then flushed; late commit of a flushed id is ignored
    issue(4'd5, 32'h00500053);
    tick();
    issue(4'd6, 32'h00600053);
    tick();
    idle();
    settle();
    check("three_count", 32'(count), 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check("flush_count", 32'(count), 0);
    commit(4'd5, 1'b0);
    tick();
    idle();
    settle();
    check("late_commit_count", 32'(count), 0);
    check("late_commit_disp", 32'(disp_valid), 0);

    // 3 entries queued then reset for one cycle
    for (int i = 8; i < 11; i++) begin
      issue(4'(i), 32'h00000053 | (32'(i) << 7));
      tick();
    end
    idle();
    commit(4'd8, 1'b0);
    disp_ready = 1'b0;
    tick();
    idle();
    rst_n = 1'b0;
    settle();
    check("rst_mid_ready", 32'(issue_ready), 0);
    check("rst_mid_disp_valid", 32'(disp_valid), 0);
    tick();
    rst_n = 1'b1;
    disp_ready = 1'b1;
    settle();
    check("rst_mid_count", 32'(count), 0);
    check("rst_mid_disp_after", 32'(disp_valid), 0);
    commit(4'd9, 1'b0);
    tick();
    idle();
    settle();
    check("rst_late_commit", 32'(count), 0);

    // issue and pop in the same cycle leaves count unchanged
    issue(4'd11, 32'h00B00053);
    commit(4'd11, 1'b0);
    sb.push_back('{4'd11, 32'h00B00053});
    tick();
    issue(4'd12, 32'h00C00053);
    commit(4'd12, 1'b0);
    sb.push_back('{4'd12, 32'h00C00053});
    settle();
    check("simul_count_before", 32'(count), 1);
    tick();
    idle();
    settle();
    check("simul_count_after", 32'(count), 1);
    tick();
    check("simul_drained", 32'(count), 0);

    tick();
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvfpm_xif_issue_queue.md
# rvfpm_xif_issue_queue

Parametrised CORE-V-XIF issue front-end for the rvfpm FPU model. Decodes each offered instruction, returns the issue response in the same cycle, buffers accepted instructions in a DEPTH-entry in-order queue, and tracks commit/kill per transaction id. Only committed instructions are dispatched to the FPU execution pipeline. Sits between the XIF issue/commit interfaces and the rvfpm execute stage.

## Interface
- X_ID_WIDTH, 4: transaction id width.
- X_NUM_RS, 3: number of integer source operands on the issue interface.
- X_RFR_WIDTH, 32: integer operand width.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- issue_valid  in  1  issue request valid.
- issue_ready  out  1  queue can take the request.
- issue_req  in  x_issue_req_t  instr, mode, id, rs, rs_valid, ecs, ecs_valid.
- issue_resp  out  x_issue_resp_t  combinational decode response.
- commit_valid  in  1  commit transaction valid.
- commit_id  in  X_ID_WIDTH  id being committed or killed.
- commit_kill  in  1  1 = kill, 0 = commit.
- flush  in  1  drop all entries.
- disp_valid  out  1  head entry committed and available.
- disp_ready  in  1  execute stage takes the head entry.
- disp_instr  out  32  head instruction.
- disp_id  out  X_ID_WIDTH  head id.
- disp_rs  out  X_NUM_RS*X_RFR_WIDTH  head operands.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Decode is combinational on issue_req.instr[6:0]. accept=1 for the following opcodes: OP-FP 1010011, FMADD 1000011, FMSUB 1000111, FNMSUB 1001011, FNMADD 1001111, LOAD-FP 0000111, STORE-FP 0100111. accept=0 for all other opcodes.
- writeback=1 when the opcode is OP-FP and funct5 (instr[31:27]) is 11000, 11100 or 10100.
- loadstore=1 for LOAD-FP and STORE-FP.
- dualwrite, dualread, ecswrite and exc are always 0.
- needs_rs=1 for LOAD-FP and STORE-FP, and for OP-FP with funct5 11010 or 11110.
- issue_ready = rst_n & !full & (!needs_rs | rs_valid[0]).
- Issue handshake: a transaction occurs when issue_valid & issue_ready.
  - If accept=1, the tail entry is written with {instr, id, rs}, valid=1, committed=0, killed=0.
  - If accept=0, nothing is stored.
- Commit: when commit_valid is high, the valid entry with a matching id that is neither committed nor killed is updated. commit_kill=0 sets committed; commit_kill=1 sets killed. If no entry matches, the commit is ignored.
- Commit in the same cycle as the issue of the same id applies to the entry being written.
- Dispatch: disp_valid = head.valid & head.committed & !head.killed. The head is popped on disp_valid & disp_ready.
- A killed head is dropped without dispatch, one entry per cycle.
- flush=1 invalidates all entries and resets both pointers at the next edge. Flush takes priority over issue, commit and pop in the same cycle.
- Pointers are $clog2(DEPTH) bits with a wrap bit. full = count==DEPTH; empty = count==0.

## Timing
- Reset (rst_n=0 at a clk edge): all entries invalid, pointers 0, count=0.
  - While rst_n=0: issue_ready=0, disp_valid=0.
  - disp_instr, disp_id and disp_rs are 0 when disp_valid=0.
- issue_resp has zero latency: it is valid in the same cycle as issue_valid and is independent of issue_ready.
- Minimum issue-to-dispatch latency is 1 cycle: issue plus commit in cycle N gives disp_valid in cycle N+1.
- A commit arriving later makes disp_valid rise the cycle after the commit.
- No full bypass: when full, a pop in cycle N raises issue_ready in cycle N+1, not N.
- Simultaneous issue and pop when not full: count is unchanged.
- A killed head makes no disp_valid pulse. The next entry can dispatch in the cycle after the drop.
- rst_n=0 mid-operation discards every entry at that edge, identically to flush.

## Structure
- Add to pa_rvfpm:
  - x_commit_t {id, commit_kill}
  - fpq_entry_t {instr, id, rs, valid, committed, killed}
  - opcode localparams OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD, OPC_LOAD_FP, OPC_STORE_FP
- Sub-module rvfpm_xif_decode: purely combinational; maps instr to {issue_resp, needs_rs}. Reused by later multi-issue front-ends.
- Queue storage, pointers and commit matching stay in rvfpm_xif_issue_queue.

## Test plan
- FADD.S (0x0020F0D3), id=3, committed in the same cycle, disp_ready=1:
  - Cycle 0: accept=1, writeback=0, loadstore=0.
  - Cycle 1: disp_valid=1, disp_id=3, disp_instr=0x0020F0D3.
- Non-FP ADD (0x00B50533), issue_valid=1: issue_resp.accept=0, issue_ready=1, count stays 0, no dispatch.
- With DEPTH=4, issue ids 0..4 back-to-back, no commits, disp_ready=0:
  - Ids 0..3 accepted; count=4; issue_ready=0 while id 4 is held.
  - Then commit id 0 with disp_ready=1: id 0 is popped, and id 4 is taken one cycle later.
- Issue ids 1 and 2, kill id 1, commit id 2: id 1 is never dispatched; disp_valid rises with disp_id=2 at most 2 cycles after the commit.
- FLW (opcode 0000111) with rs_valid[0]=0: issue_ready=0 until rs_valid[0]=1, then accepted with loadstore=1.
- With 3 entries queued:
  - flush=1 gives count=0 next cycle.
  - Separately, rst_n=0 for one cycle gives count=0 and disp_valid=0.
  - A later commit of a flushed id is ignored.
